// File: rtl/arm_timer_pkg.sv
// Register map, field positions and the byte-enable merge for arm_timer_irq.
// No logic. No flow control.
package arm_timer_pkg;

    localparam logic [4:0] LOAD_OFS    = 5'h00;
    localparam logic [4:0] VALUE_OFS   = 5'h04;
    localparam logic [4:0] CTRL_OFS    = 5'h08;
    localparam logic [4:0] STATUS_OFS  = 5'h0C;
    localparam logic [4:0] CAPTURE_OFS = 5'h10;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_PERIODIC     = 1;
    localparam int CTRL_IRQEN        = 2;
    localparam int CTRL_PRESCALE_LSB = 4;
    localparam int STATUS_PEND       = 0;

    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/arm_timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled, tick on the terminal count.
// Latency: tick is combinational from the registered count. No backpressure.
module arm_timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;

    // A clear (LOAD write) suppresses the tick so no expiry lands on that edge.
    assign tick = en && !clr && (cnt_q == prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!en || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/arm_timer_irq.sv
// Memory-mapped down-counting timer with active-low IRQ; ARM_TIMER_CAPTURE_EN adds CAPTURE.
// Latency: reads combinational, writes take effect at the clock edge, nIRQ lags PEND by 1.
// Backpressure: none, every access completes in the cycle it is presented.
module arm_timer_irq
    import arm_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sel,
    output logic        nIRQ
);

    logic [4:0] ofs;
`ifdef ARM_TIMER_CAPTURE_EN
    localparam int WIN_LSB = 5;
    assign ofs = {memaddr[4:2], 2'b00};
`else
    localparam int WIN_LSB = 4;
    assign ofs = {1'b0, memaddr[3:2], 2'b00};
`endif

    assign sel = (memaddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);

    logic [31:0]           load_q, value_q;
    logic                  en_q, periodic_q, irqen_q, pend_q, nirq_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [31:0]           ctrl_rd, load_new, ctrl_new;
    logic                  wr, wr_load, wr_ctrl, wr_status, pend_clr, tick, expire;

    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[CTRL_EN]       = en_q;
        ctrl_rd[CTRL_PERIODIC] = periodic_q;
        ctrl_rd[CTRL_IRQEN]    = irqen_q;
        ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_W] = prescale_q;
    end

    assign wr        = sel && memwrite;
    assign wr_load   = wr && (ofs == LOAD_OFS);
    assign wr_ctrl   = wr && (ofs == CTRL_OFS);
    assign wr_status = wr && (ofs == STATUS_OFS);
    assign pend_clr  = wr_status && be[0] && writedata[STATUS_PEND];
    assign load_new  = apply_be(load_q, writedata, be);
    assign ctrl_new  = apply_be(ctrl_rd, writedata, be);
    assign expire    = tick && (value_q == '0);

    logic unused_bits;
    assign unused_bits = ^{memaddr[1:0], ctrl_new};

    arm_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en_q),
        .clr      (wr_load),
        .prescale (prescale_q),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q     <= '0;
            value_q    <= '0;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irqen_q    <= 1'b0;
            prescale_q <= '0;
            pend_q     <= 1'b0;
            nirq_q     <= 1'b1;
        end else begin
            if (wr_load) begin
                load_q  <= load_new;
                value_q <= load_new;
            end else if (tick) begin
                if (value_q != '0)  value_q <= value_q - 32'd1;
                else if (periodic_q) value_q <= load_q;
            end

            // Software's CTRL write overrides the one-shot auto-disable.
            if (wr_ctrl) begin
                en_q       <= ctrl_new[CTRL_EN];
                periodic_q <= ctrl_new[CTRL_PERIODIC];
                irqen_q    <= ctrl_new[CTRL_IRQEN];
                prescale_q <= ctrl_new[CTRL_PRESCALE_LSB +: PRESCALE_W];
            end else if (expire && !periodic_q) begin
                en_q <= 1'b0;
            end

            if (expire)        pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;

            nirq_q <= ~(pend_q & irqen_q);
        end
    end

    assign nIRQ = nirq_q;

`ifdef ARM_TIMER_CAPTURE_EN
    logic [31:0] cyc_q, capture_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q     <= '0;
            capture_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (expire) capture_q <= cyc_q;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        if (sel && memread) begin
            case (ofs)
                LOAD_OFS:    readdata = load_q;
                VALUE_OFS:   readdata = value_q;
                CTRL_OFS:    readdata = ctrl_rd;
                STATUS_OFS:  readdata[STATUS_PEND] = pend_q;
`ifdef ARM_TIMER_CAPTURE_EN
                CAPTURE_OFS: readdata = capture_q;
`endif
                default:     readdata = '0;
            endcase
        end
    end

endmodule
